// File: rtl/int_fp_mul_pipe.sv
// Pipelined INT8 / FP16 multiplier with valid/ready flow control and tag pass-through.
// Each operation carries its own mode (INT8 signed or IEEE half) and an opaque tag.
// FP16 results carry {invalid, overflow, underflow} flags. A sticky register and a
// saturating counter record flagged results as they leave the block.
// Optional feature macro: FP_ROUND_NEAREST_EN selects round-to-nearest-even for the
// FP16 mantissa. When it is undefined the mantissa is truncated toward zero.
module int_fp_mul_pipe #(
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_c,
    output logic [2:0]       out_flags,
    output logic             out_mode,
    output logic [TAG_W-1:0] out_tag,
    input  logic             err_clr,
    output logic [2:0]       err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [15:0] QNAN = 16'h7E00;

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    logic       sign_p;
    logic [4:0] ea, eb;
    logic [9:0] ma, mb;
    logic       a_nan, a_inf, a_zero;
    logic       b_nan, b_inf, b_zero;

    assign sign_p = in_a[15] ^ in_b[15];
    assign ea     = in_a[14:10];
    assign eb     = in_b[14:10];
    assign ma     = in_a[9:0];
    assign mb     = in_b[9:0];

    // Subnormals (exponent 0) are flushed to zero on input.
    assign a_nan  = (ea == 5'h1F) && (ma != 10'h0);
    assign a_inf  = (ea == 5'h1F) && (ma == 10'h0);
    assign a_zero = (ea == 5'h00);
    assign b_nan  = (eb == 5'h1F) && (mb != 10'h0);
    assign b_inf  = (eb == 5'h1F) && (mb == 10'h0);
    assign b_zero = (eb == 5'h00);

    // ------------------------------------------------------------------
    // INT8 product
    // ------------------------------------------------------------------
    logic signed [15:0] int_a, int_b, int_p;

    assign int_a = {{8{in_a[7]}}, in_a[7:0]};
    assign int_b = {{8{in_b[7]}}, in_b[7:0]};
    assign int_p = int_a * int_b;

    // ------------------------------------------------------------------
    // FP16 significand product and rounding
    // ------------------------------------------------------------------
    logic [21:0] sig_a, sig_b;
    logic [11:0] prod_hi;     // product bits [21:10]
    logic [9:0]  mant_trunc;
    logic        round_up;

    assign sig_a = {11'h0, 1'b1, ma};
    assign sig_b = {11'h0, 1'b1, mb};

`ifdef FP_ROUND_NEAREST_EN
    logic [21:0] prod;
    logic        guard;
    logic        sticky;

    assign prod    = sig_a * sig_b;
    assign prod_hi = prod[21:10];
    assign guard   = prod[21] ? prod[10] : prod[9];
    assign sticky  = prod[21] ? (|prod[9:0]) : (|prod[8:0]);
`else
    // Only the top bits matter when truncating.
    assign prod_hi = 12'((sig_a * sig_b) >> 10);
`endif

    assign mant_trunc = prod_hi[11] ? prod_hi[10:1] : prod_hi[9:0];

`ifdef FP_ROUND_NEAREST_EN
    assign round_up = guard & (sticky | mant_trunc[0]);
`else
    assign round_up = 1'b0;
`endif

    logic [10:0]       mant_sum;
    logic signed [7:0] exp_sum;
    logic signed [7:0] exp_fin;

    // A mantissa carry out (all-ones + 1) leaves zero mantissa and bumps the exponent.
    assign mant_sum = {1'b0, mant_trunc} + {10'h0, round_up};
    assign exp_sum  = $signed({3'b000, ea}) + $signed({3'b000, eb})
                    + $signed({7'h00, prod_hi[11]}) - 8'sd15;
    assign exp_fin  = exp_sum + $signed({7'h00, mant_sum[10]});

    // ------------------------------------------------------------------
    // Result selection for the operation at the input
    // ------------------------------------------------------------------
    logic [15:0] res_c;
    logic [2:0]  res_flags;

    // Special-value priority: NaN / Inf*0, then Inf, then zero, then the normal path.
    always_comb begin
        res_c     = 16'h0;
        res_flags = 3'b000;
        if (!in_mode) begin
            res_c = int_p;
        end else if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res_c     = QNAN;
            res_flags = 3'b100;
        end else if (a_inf || b_inf) begin
            res_c = {sign_p, 5'h1F, 10'h0};
        end else if (a_zero || b_zero) begin
            res_c = {sign_p, 15'h0};
        end else if (exp_fin >= 8'sd31) begin
            res_c     = {sign_p, 5'h1F, 10'h0};
            res_flags = 3'b010;
        end else if (exp_fin <= 8'sd0) begin
            res_c     = {sign_p, 15'h0};
            res_flags = 3'b001;
        end else begin
            res_c = {sign_p, exp_fin[4:0], mant_sum[9:0]};
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [PIPE_STAGES-1:0] v_q;
    logic [15:0]            c_q     [PIPE_STAGES];
    logic [2:0]             flags_q [PIPE_STAGES];
    logic                   mode_q  [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_q   [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] ld;

    // A stage may load if it or any stage after it is empty, or the output drains.
    // Written without a ripple over ld itself so the chain stays acyclic.
    always_comb begin
        logic all_full;
        ld = '0;
        for (int i = 0; i < int'(PIPE_STAGES); i++) begin
            all_full = 1'b1;
            for (int j = i; j < int'(PIPE_STAGES); j++) begin
                all_full = all_full & v_q[j];
            end
            ld[i] = out_ready | ~all_full;
        end
    end

    assign in_ready = ld[0];

    // Shift operations forward; payload only moves when a valid op moves with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < int'(PIPE_STAGES); i++) begin
                c_q[i]     <= 16'h0;
                flags_q[i] <= 3'b000;
                mode_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else begin
            if (ld[0]) begin
                v_q[0] <= in_valid;
                if (in_valid) begin
                    c_q[0]     <= res_c;
                    flags_q[0] <= res_flags;
                    mode_q[0]  <= in_mode;
                    tag_q[0]   <= in_tag;
                end
            end
            for (int i = 1; i < int'(PIPE_STAGES); i++) begin
                if (ld[i]) begin
                    v_q[i] <= v_q[i-1];
                    if (v_q[i-1]) begin
                        c_q[i]     <= c_q[i-1];
                        flags_q[i] <= flags_q[i-1];
                        mode_q[i]  <= mode_q[i-1];
                        tag_q[i]   <= tag_q[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = v_q[PIPE_STAGES-1];
    assign out_c     = c_q[PIPE_STAGES-1];
    assign out_flags = flags_q[PIPE_STAGES-1];
    assign out_mode  = mode_q[PIPE_STAGES-1];
    assign out_tag   = tag_q[PIPE_STAGES-1];

    // ------------------------------------------------------------------
    // Error tracking on output transfers
    // ------------------------------------------------------------------
    logic             out_xfer;
    logic [2:0]       sticky_d, sticky_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign out_xfer = out_valid & out_ready;

    // Clear takes effect first so an error arriving on the same edge is kept.
    always_comb begin
        sticky_d = err_clr ? 3'b000 : sticky_q;
        cnt_d    = err_clr ? '0 : cnt_q;
        if (out_xfer) begin
            sticky_d = sticky_d | out_flags;
            if ((|out_flags) && (cnt_d != {CNT_W{1'b1}})) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    // Error state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 3'b000;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_int_fp_mul_pipe.sv
// Self-checking bench for int_fp_mul_pipe: a real-arithmetic reference model with a
// scoreboard checked every cycle, plus directed cases with literal expectations.
module tb_int_fp_mul_pipe;

    localparam int P  = 2;
    localparam int TW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [15:0]   in_a = 16'h0;
    logic [15:0]   in_b = 16'h0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   out_c;
    logic [2:0]    out_flags;
    logic          out_mode;
    logic [TW-1:0] out_tag;
    logic          err_clr = 1'b0;
    logic [2:0]    err_sticky;
    logic [CW-1:0] err_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0: ready high, 1: toggle, 2: random, other: ready low

    int_fp_mul_pipe #(
        .PIPE_STAGES (P),
        .TAG_W       (TW),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c      (out_c),
        .out_flags  (out_flags),
        .out_mode   (out_mode),
        .out_tag    (out_tag),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: returns {flags, product}, computed with integer and real arithmetic.
    function automatic logic [18:0] model(input logic mode, input logic [15:0] a,
                                          input logic [15:0] b);
        int  ia, ib, ip, ea, eb, e, m;
        real x, frac, fl;
        logic s;
        if (!mode) begin
            ia = int'($signed(a[7:0]));
            ib = int'($signed(b[7:0]));
            ip = ia * ib;
            return {3'b000, ip[15:0]};
        end
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0) ||
            (ea == 31 && eb == 0) || (eb == 31 && ea == 0))
            return {3'b100, 16'h7E00};
        if (ea == 31 || eb == 31) return {3'b000, s, 5'h1F, 10'h0};
        if (ea == 0 || eb == 0) return {3'b000, s, 15'h0};
        x = (1.0 + real'(int'(a[9:0])) / 1024.0) * (1.0 + real'(int'(b[9:0])) / 1024.0);
        e = ea + eb - 15;
        if (x >= 2.0) begin
            x = x / 2.0;
            e++;
        end
        frac = (x - 1.0) * 1024.0;
        fl   = $floor(frac);
        m    = int'(fl);
`ifdef FP_ROUND_NEAREST_EN
        if ((frac - fl > 0.5) || (frac - fl == 0.5 && (m % 2) == 1)) m++;
        if (m == 1024) begin
            m = 0;
            e++;
        end
`endif
        if (e >= 31) return {3'b010, s, 5'h1F, 10'h0};
        if (e <= 0) return {3'b001, s, 15'h0};
        return {3'b000, s, e[4:0], m[9:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom % 8)
            0: v[14:10] = 5'h1F;
            1: v[14:10] = 5'h00;
            2: v[14:10] = 5'h01;
            3: v[14:10] = 5'h1E;
            default: ;
        endcase
        return v;
    endfunction

    // Consumer ready pattern, changed after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = ($urandom % 3) != 0;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard and error-register model, evaluated every falling edge.
    logic [23:0] exp_q[$];
    initial begin
        logic        hold_v;
        logic [15:0] hold_c;
        logic [2:0]  hold_f;
        logic        hold_m;
        logic [3:0]  hold_t;
        logic [2:0]  m_sticky, nxt_sticky;
        logic [7:0]  m_cnt, nxt_cnt;
        logic [23:0] e;
        hold_v = 1'b0;
        m_sticky = 3'b000;
        m_cnt = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hold_v = 1'b0;
                m_sticky = 3'b000;
                m_cnt = 8'h00;
                check("rst_out_valid", 32'(out_valid), 0);
                check("rst_out_c", 32'(out_c), 0);
                check("rst_out_flags", 32'(out_flags), 0);
                check("rst_out_tag_mode", {27'h0, out_mode, out_tag}, 0);
                check("rst_err", {21'h0, err_sticky, err_cnt}, 0);
            end else begin
                check("err_sticky", 32'(err_sticky), 32'(m_sticky));
                check("err_cnt", 32'(err_cnt), 32'(m_cnt));
                if (hold_v) begin
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_c", 32'(out_c), 32'(hold_c));
                    check("stall_flags_mode_tag", {24'h0, out_flags, out_mode, out_tag},
                          {24'h0, hold_f, hold_m, hold_t});
                end
                hold_v = out_valid && !out_ready;
                hold_c = out_c;
                hold_f = out_flags;
                hold_m = out_mode;
                hold_t = out_tag;
                nxt_sticky = err_clr ? 3'b000 : m_sticky;
                nxt_cnt    = err_clr ? 8'h00 : m_cnt;
                if (out_valid && out_ready) begin
                    check("result_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("res_c", 32'(out_c), 32'(e[15:0]));
                        check("res_flags", 32'(out_flags), 32'(e[18:16]));
                        check("res_tag", 32'(out_tag), 32'(e[22:19]));
                        check("res_mode", 32'(out_mode), 32'(e[23]));
                        nxt_sticky = nxt_sticky | e[18:16];
                        if (e[18:16] != 3'b000 && nxt_cnt != 8'hFF) nxt_cnt = nxt_cnt + 8'h01;
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back({in_mode, in_tag, model(in_mode, in_a, in_b)});
                m_sticky = nxt_sticky;
                m_cnt = nxt_cnt;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic send(input logic m, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] t);
        in_valid = 1'b1;
        in_mode = m;
        in_a = a;
        in_b = b;
        in_tag = t;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("send_accept", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Single op into an empty pipe with the consumer ready; checks latency and result.
    task automatic run_one(input string name, input logic m, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp_c,
                           input logic [2:0] exp_f);
        int t0;
        t0 = cyc;
        send(m, a, b, 4'h5);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, "_valid"}, 32'(out_valid), 1);
        check({name, "_latency"}, 32'(cyc - t0), 32'(P));
        check({name, "_c"}, 32'(out_c), 32'(exp_c));
        check({name, "_flags"}, 32'(out_flags), 32'(exp_f));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 0);
    endtask

    logic [15:0] r5;

    initial begin
`ifdef FP_ROUND_NEAREST_EN
        r5 = 16'h4082;
`else
        r5 = 16'h4081;
`endif
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pin the model to hand-computed values.
        check("pin_int", 32'(model(1'b0, 16'h00FD, 16'h0007)), 32'h0FFEB);
        check("pin_fp_2", 32'(model(1'b1, 16'h3C00, 16'h4000)), 32'h04000);
        check("pin_fp_225", 32'(model(1'b1, 16'h3E00, 16'h3E00)), 32'h04080);
        check("pin_ovf", 32'(model(1'b1, 16'h7800, 16'h7800)), 32'h27C00);
        check("pin_unf", 32'(model(1'b1, 16'h0400, 16'h0400)), 32'h10000);
        check("pin_inv", 32'(model(1'b1, 16'h7C00, 16'h0000)), 32'h47E00);
        check("pin_rnd", 32'(model(1'b1, 16'h3E01, 16'h3E01)), 32'(r5));

        @(posedge clk);
        #1;
        run_one("t1_int", 1'b0, 16'h00FD, 16'h0007, 16'hFFEB, 3'b000);
        run_one("t2_a", 1'b1, 16'h3C00, 16'h4000, 16'h4000, 3'b000);
        run_one("t2_b", 1'b1, 16'h3E00, 16'h3E00, 16'h4080, 3'b000);
        run_one("t2_c", 1'b1, 16'h8000, 16'h3C00, 16'h8000, 3'b000);
        run_one("t3_ovf", 1'b1, 16'h7800, 16'h7800, 16'h7C00, 3'b010);
        run_one("t3_unf", 1'b1, 16'h0400, 16'h0400, 16'h0000, 3'b001);
        run_one("t3_inv", 1'b1, 16'h7C00, 16'h0000, 16'h7E00, 3'b100);
        check("t3_sticky", 32'(err_sticky), 32'h7);
        check("t3_cnt", 32'(err_cnt), 3);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("t3_clr_sticky", 32'(err_sticky), 0);
        check("t3_clr_cnt", 32'(err_cnt), 0);
        run_one("t5_rnd", 1'b1, 16'h3E01, 16'h3E01, r5, 3'b000);

        // Stream of 8 mixed-mode ops with a toggling consumer.
        rdy_mode = 1;
        for (int t = 0; t < 8; t++) send(t[0], rand_op(), rand_op(), 4'(t));
        drain();

        // Randomized traffic with random back-pressure and occasional clears.
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            err_clr = ($urandom % 40) == 0;
            if (($urandom % 4) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                send(1'($urandom), rand_op(), rand_op(), 4'($urandom));
            end
        end
        err_clr = 1'b0;
        rdy_mode = 0;
        drain();

        // Reset with operations in flight.
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_mode = 1'b0;
            in_a = 16'(i + 3);
            in_b = 16'h0002;
            in_tag = 4'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6_no_stale", 32'(out_valid), 0);
            check("t6_err_cnt", 32'(err_cnt), 0);
        end
        @(posedge clk);
        #1;
        run_one("t6_after", 1'b0, 16'h0080, 16'h0080, 16'h4000, 3'b000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
